// File: rtl/alarm_tone_pkg.sv
// rtl/alarm_tone_pkg.sv - shared states, default timing and priority helper for the alarm tone scheduler
package alarm_tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_TICK_DIV  = 50000;
    localparam int unsigned DEF_ON_TICKS  = 100;
    localparam int unsigned DEF_OFF_TICKS = 100;
    localparam int unsigned DEF_GAP_TICKS = 500;

    // Lowest set bit wins; an empty vector returns 0 and callers gate on |req.
    function automatic int prio_index(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// rtl/alarm_tick_gen.sv - TICK_DIV prescaler with synchronous clear and tick output
module alarm_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          at_wrap;

    // tick is not gated by clr so the scheduler can derive clr from tick without a loop
    assign at_wrap = (cnt == CW'(TICK_DIV - 1));
    assign tick    = at_wrap;

    // Free-running divider, restarted on every scheduler phase change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || at_wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alarm_tone_scheduler.sv
// rtl/alarm_tone_scheduler.sv - fixed-priority alarm beep sequencer; optional ALARM_TONE_MUTE_EN adds a mute input
module alarm_tone_scheduler
    import alarm_tone_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
    localparam int unsigned SEL_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef ALARM_TONE_MUTE_EN
    input  logic               mute,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic               tone_en,
    output logic [SEL_W-1:0]   tone_sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               burst_done
);

    localparam int unsigned PH_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned PH_MAX  = (PH_MAX0 > GAP_TICKS) ? PH_MAX0 : GAP_TICKS;
    localparam int unsigned PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned BC_W    = $clog2(NUM_REQ + 1);

    if (NUM_REQ == 0 || NUM_REQ > 32) begin : g_bad_num_req
        $error("alarm_tone_scheduler: NUM_REQ must be 1..32");
    end
    if (TICK_DIV == 0 || ON_TICKS == 0 || OFF_TICKS == 0 || GAP_TICKS == 0) begin : g_bad_timing
        $error("alarm_tone_scheduler: timing parameters must be non-zero");
    end

    state_t             state, state_next;
    logic [SEL_W-1:0]   owner, owner_next, req_idx;
    logic [BC_W-1:0]    beep_cnt, beep_next, beep_reload;
    logic [PH_W-1:0]    ph_cnt, ph_next;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               tick, tick_clr, done_next;
    logic               tone_en_q;

    assign req_idx     = SEL_W'(prio_index(32'(req)));
    assign beep_reload = BC_W'(NUM_REQ) - BC_W'(req_idx);
    assign tick_clr    = (state_next != state) || (state == ST_IDLE);

    alarm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            beep_cnt   <= '0;
            ph_cnt     <= '0;
            tone_en_q  <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            beep_cnt   <= beep_next;
            ph_cnt     <= ph_next;
            tone_en_q  <= (state_next == ST_ON);
            grant      <= (state_next != ST_IDLE) ? owner_onehot : '0;
            busy       <= (state_next != ST_IDLE);
            burst_done <= done_next;
        end
    end

    // Next-state: arbitration in IDLE and at OFF end, phase timing in ticks
    always_comb begin
        state_next = state;
        owner_next = owner;
        beep_next  = beep_cnt;
        ph_next    = ph_cnt;
        done_next  = 1'b0;
        if (tick && state != ST_IDLE) ph_next = ph_cnt + PH_W'(1);
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    owner_next = req_idx;
                    beep_next  = beep_reload;
                    state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (tick && ph_cnt == PH_W'(ON_TICKS - 1)) state_next = ST_OFF;
            end
            ST_OFF: begin
                if (tick && ph_cnt == PH_W'(OFF_TICKS - 1)) begin
                    if (|req && req_idx < owner) begin
                        owner_next = req_idx;
                        beep_next  = beep_reload;
                        state_next = ST_ON;
                    end else if (beep_cnt == BC_W'(1)) begin
                        beep_next  = '0;
                        done_next  = 1'b1;
                        state_next = ST_GAP;
                    end else begin
                        beep_next  = beep_cnt - BC_W'(1);
                        state_next = ST_ON;
                    end
                end
            end
            ST_GAP: begin
                if (tick && ph_cnt == PH_W'(GAP_TICKS - 1)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next != state) ph_next = '0;
    end

    // One-hot view of the owner that the grant register loads
    always_comb begin
        owner_onehot             = '0;
        owner_onehot[owner_next] = 1'b1;
    end

    assign tone_sel = owner;
`ifdef ALARM_TONE_MUTE_EN
    assign tone_en = tone_en_q && !(mute && owner != '0);
`else
    assign tone_en = tone_en_q;
`endif

endmodule

// File: tb/tb_alarm_tone_scheduler.sv
// tb/tb_alarm_tone_scheduler.sv - randomized and directed bench against a cycle-count reference model
module tb_alarm_tone_scheduler;

    localparam int NUM_REQ = 4;
    localparam int TD      = 4;
    localparam int ON_C    = 2 * TD;
    localparam int OFF_C   = 2 * TD;
    localparam int GAP_C   = 3 * TD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mute = 1'b0;
    logic [3:0] req = '0;
    logic       tone_en;
    logic [1:0] tone_sel;
    logic [3:0] grant;
    logic       busy;
    logic       burst_done;

    int tests_run = 0;
    int tests_failed = 0;

    alarm_tone_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .TICK_DIV  (TD),
        .ON_TICKS  (2),
        .OFF_TICKS (2),
        .GAP_TICKS (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ALARM_TONE_MUTE_EN
        .mute       (mute),
`endif
        .req        (req),
        .tone_en    (tone_en),
        .tone_sel   (tone_sel),
        .grant      (grant),
        .busy       (busy),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    // Reference model: phase name, cycles left in phase, owner, beeps left
    string m_phase = "IDLE";
    int    m_left  = 0;
    int    m_owner = 0;
    int    m_beeps = 0;
    bit    m_done  = 0;

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_phase = "IDLE"; m_left = 0; m_owner = 0; m_beeps = 0; m_done = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        int w;
        w = lowest(r);
        m_done = 0;
        if (m_phase == "IDLE") begin
            if (w >= 0) begin
                m_owner = w; m_beeps = NUM_REQ - w; m_phase = "ON"; m_left = ON_C;
            end
        end else if (m_phase == "ON") begin
            m_left--;
            if (m_left == 0) begin m_phase = "OFF"; m_left = OFF_C; end
        end else if (m_phase == "OFF") begin
            m_left--;
            if (m_left == 0) begin
                m_beeps--;
                if (w >= 0 && w < m_owner) begin
                    m_owner = w; m_beeps = NUM_REQ - w; m_phase = "ON"; m_left = ON_C;
                end else if (m_beeps == 0) begin
                    m_done = 1; m_phase = "GAP"; m_left = GAP_C;
                end else begin
                    m_phase = "ON"; m_left = ON_C;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) m_phase = "IDLE";
        end
    endfunction

    function automatic logic [8:0] model_vec();
        logic       t;
        logic [3:0] g;
        t = (m_phase == "ON");
`ifdef ALARM_TONE_MUTE_EN
        if (mute && m_owner != 0) t = 1'b0;
`endif
        g = (m_phase != "IDLE") ? (4'b0001 << m_owner) : 4'b0000;
        return {t, 2'(m_owner), g, (m_phase != "IDLE"), m_done};
    endfunction

    // Drive one cycle of req, advance the model on the same edge, sample 1 time unit later
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({tone_en, tone_sel, grant, busy, burst_done} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got %b expected %b", {tone_en, tone_sel, grant, busy, burst_done}, 9'b0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000);
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL reset_idle cyc%0d: got %b expected %b", i, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
    endtask

    task automatic test_single_pulse();
        int on_cnt = 0;
        int done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(i == 0 ? 4'b0100 : 4'b0000);
            if (i == 0) begin
                tests_run++;
                if (grant !== 4'b0100 || tone_sel !== 2'd2) begin
                    tests_failed++;
                    $display("FAIL pulse_grant: got grant=%b sel=%0d expected grant=0100 sel=2", grant, tone_sel);
                end
            end
            on_cnt += tone_en;
            done_cnt += burst_done;
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL pulse cyc%0d: got %b expected %b", i, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
        tests_run++;
        if (on_cnt != 16 || done_cnt != 1 || grant !== 4'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_totals: got on=%0d done=%0d grant=%b busy=%b expected on=16 done=1 grant=0000 busy=0", on_cnt, done_cnt, grant, busy);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 150; i++) begin
            cycle(i == 0 ? 4'b1010 : (i < 70 ? 4'b1000 : 4'b0000));
            if (i == 0) begin
                tests_run++;
                if (grant !== 4'b0010 || tone_sel !== 2'd1) begin
                    tests_failed++;
                    $display("FAIL simul_grant: got grant=%b sel=%0d expected grant=0010 sel=1", grant, tone_sel);
                end
            end
            if (i == 61) begin
                tests_run++;
                if (grant !== 4'b1000) begin
                    tests_failed++;
                    $display("FAIL simul_next_owner: got grant=%b expected 1000", grant);
                end
            end
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL simul cyc%0d: got %b expected %b", i, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
    endtask

    task automatic test_preempt();
        int early_done = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(i < 3 ? 4'b1000 : (i < 20 ? 4'b1001 : (i < 110 ? 4'b1000 : 4'b0000)));
            if (i < 16) early_done += burst_done;
            if (i == 16) begin
                tests_run++;
                if (grant !== 4'b0001 || tone_en !== 1'b1 || early_done != 0) begin
                    tests_failed++;
                    $display("FAIL preempt_switch: got grant=%b tone=%b done=%0d expected grant=0001 tone=1 done=0", grant, tone_en, early_done);
                end
            end
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL preempt cyc%0d: got %b expected %b", i, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_done = -1;
        int second_done = -1;
        for (int i = 0; i < 140; i++) begin
            cycle(i < 100 ? 4'b0100 : 4'b0000);
            if (burst_done === 1'b1) begin
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL repeat cyc%0d: got %b expected %b", i, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
        tests_run++;
        if (first_done != 32 || second_done - first_done != 45) begin
            tests_failed++;
            $display("FAIL repeat_spacing: got first=%0d second=%0d expected first=32 spacing=45", first_done, second_done);
        end
    endtask

    task automatic test_reset_mid_on();
        for (int i = 0; i < 4; i++) cycle(i == 0 ? 4'b0010 : 4'b0000);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({tone_en, tone_sel, grant, busy, burst_done} !== 9'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b expected %b", {tone_en, tone_sel, grant, busy, burst_done}, 9'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0000);
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL post_reset_idle cyc%0d: got %b expected %b", i, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i >= 1400) r = '0;
            else if ($urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15));
            cycle(r);
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL random cyc%0d req=%b: got %b expected %b", i, r, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
    endtask

`ifdef ALARM_TONE_MUTE_EN
    task automatic test_mute();
        int on1 = 0;
        int done1 = 0;
        int on0 = 0;
        mute = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle(i == 0 ? 4'b0010 : (i == 100 ? 4'b0001 : 4'b0000));
            if (i < 100) begin on1 += tone_en; done1 += burst_done; end
            else on0 += tone_en;
            tests_run++;
            if ({tone_en, tone_sel, grant, busy, burst_done} !== model_vec()) begin
                tests_failed++;
                $display("FAIL mute cyc%0d: got %b expected %b", i, {tone_en, tone_sel, grant, busy, burst_done}, model_vec());
            end
        end
        tests_run++;
        if (on1 != 0 || done1 != 1 || on0 != 32) begin
            tests_failed++;
            $display("FAIL mute_totals: got on1=%0d done1=%0d on0=%0d expected 0 1 32", on1, done1, on0);
        end
        mute = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_pulse();
        test_simultaneous();
        test_preempt();
        test_back_to_back();
        test_reset_mid_on();
        test_random();
`ifdef ALARM_TONE_MUTE_EN
        test_mute();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
